// File: rtl/sata_oob_control_pkg.sv
// SATA OOB shared definitions: state codes and primitive words.
// Also imported by the SATA link layer so both sides agree on encodings.
package sata_oob_control_pkg;

    typedef enum logic [3:0] {
        ST_RESET              = 4'd0,
        ST_WAIT_PHY           = 4'd1,
        ST_SEND_COMRESET      = 4'd2,
        ST_WAIT_COMRESET_DONE = 4'd3,
        ST_WAIT_COMINIT       = 4'd4,
        ST_SEND_COMWAKE       = 4'd5,
        ST_WAIT_COMWAKE_DONE  = 4'd6,
        ST_WAIT_COMWAKE       = 4'd7,
        ST_WAIT_IDLE_END      = 4'd8,
        ST_SEND_D10_2         = 4'd9,
        ST_SEND_ALIGN         = 4'd10,
        ST_READY              = 4'd11
    } oob_state_t;

    localparam logic [31:0] PRIM_ALIGN = 32'h7B4A4ABC;
    localparam logic [3:0]  K_ALIGN    = 4'b0001;
    localparam logic [31:0] PRIM_D10_2 = 32'h4A4A4A4A;

endpackage

// File: rtl/sata_prim_detect.sv
// Registered receive-primitive classifier, fixed one-cycle latency.
// Ports: clk, rst (sync, high); rx_data/rx_char_is_k in; align_det, prim_det out.
module sata_prim_detect
    import sata_oob_control_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_char_is_k,
    output logic        align_det,
    output logic        prim_det
);

    logic is_align;

    assign is_align = (rx_data == PRIM_ALIGN) && (rx_char_is_k == K_ALIGN);

    always_ff @(posedge clk) begin
        if (rst) begin
            align_det <= 1'b0;
            prim_det  <= 1'b0;
        end else begin
            align_det <= is_align;
            // Any K-led word other than ALIGN counts as a non-ALIGN primitive.
            prim_det  <= rx_char_is_k[0] && !is_align;
        end
    end

endmodule

// File: rtl/sata_oob_control.sv
// SATA host OOB sequencer: COMRESET/COMWAKE, D10.2/ALIGN handshake, link up.
// Ports: clk, rst (sync, high); PHY status and RX words in; TX OOB/data, link/state/retry out.
module sata_oob_control
    import sata_oob_control_pkg::*;
#(
    parameter int COMINIT_TIMEOUT = 750000,
    parameter int ALIGN_TIMEOUT   = 66000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_phy_reset_done,
    input  logic        i_pll_detect_k,
    input  logic        i_dcm_locked,
    input  logic [2:0]  i_rx_status,
    input  logic        i_rx_elec_idle,
    input  logic [31:0] i_rx_data,
    input  logic [3:0]  i_rx_char_is_k,
    input  logic [31:0] i_user_tx_data,
    input  logic [3:0]  i_user_tx_char_is_k,
    output logic        o_tx_comm_start,
    output logic        o_tx_comm_type,
    output logic        o_tx_elec_idle,
    output logic [31:0] o_tx_data,
    output logic [3:0]  o_tx_char_is_k,
    output logic        o_link_up,
    output logic [3:0]  o_state,
    output logic [7:0]  o_retry_count
);

    localparam logic [31:0] CI_LAST = 32'(COMINIT_TIMEOUT - 1);
    localparam logic [31:0] AL_LAST = 32'(ALIGN_TIMEOUT - 1);

    oob_state_t  state_q, next_state;
    logic [31:0] timer;
    logic [1:0]  prim_cnt;
    logic [7:0]  retry;
    logic        phy_ok, timeout, take_retry;
    logic        align_det, prim_det;
    logic        d_comm_start, d_comm_type, d_elec_idle, d_link_up;
    logic [31:0] d_tx_data;
    logic [3:0]  d_tx_k;

    sata_prim_detect u_prim (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (i_rx_data),
        .rx_char_is_k (i_rx_char_is_k),
        .align_det    (align_det),
        .prim_det     (prim_det)
    );

    assign phy_ok = i_phy_reset_done && i_pll_detect_k && i_dcm_locked;

    assign timeout =
        (((state_q == ST_WAIT_COMINIT) || (state_q == ST_WAIT_COMWAKE))
            && (timer == CI_LAST))
        || ((state_q == ST_SEND_D10_2) && (timer == AL_LAST));

    // State, timer, primitive counter and retry counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_RESET;
            timer    <= '0;
            prim_cnt <= '0;
            retry    <= '0;
        end else begin
            state_q <= next_state;
            timer   <= (next_state != state_q) ? '0 : timer + 32'd1;
            if (state_q != ST_SEND_ALIGN || !prim_det)
                prim_cnt <= '0;
            else
                prim_cnt <= prim_cnt + 2'd1;
            if (take_retry && retry != 8'hFF)
                retry <= retry + 8'd1;
        end
    end

    always_comb begin
        next_state = state_q;
        take_retry = 1'b0;
        unique case (state_q)
            ST_RESET:
                next_state = ST_WAIT_PHY;
            ST_WAIT_PHY:
                if (phy_ok) next_state = ST_SEND_COMRESET;
            ST_SEND_COMRESET:
                next_state = ST_WAIT_COMRESET_DONE;
            ST_WAIT_COMRESET_DONE:
                if (i_rx_status[0]) next_state = ST_WAIT_COMINIT;
            ST_WAIT_COMINIT:
                if (i_rx_status[2]) begin
                    next_state = ST_SEND_COMWAKE;
                end else if (timeout) begin
                    next_state = ST_SEND_COMRESET;
                    take_retry = 1'b1;
                end
            ST_SEND_COMWAKE:
                next_state = ST_WAIT_COMWAKE_DONE;
            ST_WAIT_COMWAKE_DONE:
                if (i_rx_status[0]) next_state = ST_WAIT_COMWAKE;
            ST_WAIT_COMWAKE:
                if (i_rx_status[1]) begin
                    next_state = ST_WAIT_IDLE_END;
                end else if (timeout) begin
                    next_state = ST_SEND_COMRESET;
                    take_retry = 1'b1;
                end
            ST_WAIT_IDLE_END:
                if (!i_rx_elec_idle) next_state = ST_SEND_D10_2;
            ST_SEND_D10_2:
                if (align_det) begin
                    next_state = ST_SEND_ALIGN;
                end else if (timeout) begin
                    next_state = ST_SEND_COMRESET;
                    take_retry = 1'b1;
                end
            ST_SEND_ALIGN:
                // Third consecutive primitive is the one flagged now.
                if (prim_det && prim_cnt == 2'd2) next_state = ST_READY;
            ST_READY:
                if (i_rx_status[2]) next_state = ST_SEND_COMRESET;
            default:
                next_state = ST_RESET;
        endcase
        // PHY loss overrides everything, including a same-cycle timeout.
        if (state_q != ST_RESET && state_q != ST_WAIT_PHY && !phy_ok) begin
            next_state = ST_WAIT_PHY;
            take_retry = 1'b0;
        end
    end

    // Outputs are decoded from next_state so the registers line up with o_state.
    always_comb begin
        d_comm_start = (next_state == ST_SEND_COMRESET)
                    || (next_state == ST_SEND_COMWAKE);
        d_comm_type  = (next_state == ST_SEND_COMWAKE);
        d_elec_idle  = (next_state < ST_SEND_D10_2);
        d_link_up    = (next_state == ST_READY);
        d_tx_data    = '0;
        d_tx_k       = '0;
        unique case (next_state)
            ST_SEND_D10_2: begin
                d_tx_data = PRIM_D10_2;
                d_tx_k    = 4'b0000;
            end
            ST_SEND_ALIGN: begin
                d_tx_data = PRIM_ALIGN;
                d_tx_k    = K_ALIGN;
            end
            ST_READY: begin
                d_tx_data = i_user_tx_data;
                d_tx_k    = i_user_tx_char_is_k;
            end
            default: begin
                d_tx_data = '0;
                d_tx_k    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            o_tx_comm_start <= 1'b0;
            o_tx_comm_type  <= 1'b0;
            o_tx_elec_idle  <= 1'b1;
            o_tx_data       <= '0;
            o_tx_char_is_k  <= '0;
            o_link_up       <= 1'b0;
        end else begin
            o_tx_comm_start <= d_comm_start;
            o_tx_comm_type  <= d_comm_type;
            o_tx_elec_idle  <= d_elec_idle;
            o_tx_data       <= d_tx_data;
            o_tx_char_is_k  <= d_tx_k;
            o_link_up       <= d_link_up;
        end
    end

    assign o_state       = state_q;
    assign o_retry_count = retry;

endmodule

// File: tb/tb_sata_oob_control.sv
// Scoreboard bench for sata_oob_control: expected state/retry/OOB events queued
// by stimulus, popped and compared by an independent monitor.
module tb_sata_oob_control;

    localparam int CT = 50;
    localparam int AT = 40;

    localparam logic [31:0] ALIGN_W = 32'h7B4A4ABC;
    localparam logic [31:0] SYNC_W  = 32'hB5B5957C;
    localparam logic [31:0] D102_W  = 32'h4A4A4A4A;
    localparam logic [31:0] IDLE_W  = 32'h12345678;

    logic        clk = 1'b0;
    logic        rst;
    logic        phy_reset_done, pll_detect_k, dcm_locked;
    logic [2:0]  rx_status;
    logic        rx_elec_idle;
    logic [31:0] rx_data;
    logic [3:0]  rx_k;
    logic [31:0] user_data;
    logic [3:0]  user_k;
    logic        tx_comm_start, tx_comm_type, tx_elec_idle, link_up;
    logic [31:0] tx_data;
    logic [3:0]  tx_k, state;
    logic [7:0]  retry_count;

    sata_oob_control #(.COMINIT_TIMEOUT(CT), .ALIGN_TIMEOUT(AT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .i_phy_reset_done    (phy_reset_done),
        .i_pll_detect_k      (pll_detect_k),
        .i_dcm_locked        (dcm_locked),
        .i_rx_status         (rx_status),
        .i_rx_elec_idle      (rx_elec_idle),
        .i_rx_data           (rx_data),
        .i_rx_char_is_k      (rx_k),
        .i_user_tx_data      (user_data),
        .i_user_tx_char_is_k (user_k),
        .o_tx_comm_start     (tx_comm_start),
        .o_tx_comm_type      (tx_comm_type),
        .o_tx_elec_idle      (tx_elec_idle),
        .o_tx_data           (tx_data),
        .o_tx_char_is_k      (tx_k),
        .o_link_up           (link_up),
        .o_state             (state),
        .o_retry_count       (retry_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int rc;
    } exp_t;

    exp_t exp_q[$];
    int   comm_q[$];
    int   checks = 0;
    int   passed = 0;
    int   exp_retry = 0;
    bit   armed = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, req);
    endtask

    task automatic push(input int s);
        exp_t e;
        e.st = s;
        e.rc = exp_retry;
        exp_q.push_back(e);
    endtask

    // Monitor: compares every state change and every OOB burst request.
    logic [3:0] prev_state;
    logic       prev_cs;
    always @(negedge clk) begin
        if (!armed) begin
            prev_state = state;
            prev_cs    = tx_comm_start;
        end else begin
            if (state != prev_state) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL state_change: got state %0d, none expected",
                             state);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("state", state, e.st);
                    check("retry_at_state", retry_count, e.rc);
                    check("link_up", link_up, e.st == 11);
                    check("tx_elec_idle", tx_elec_idle, e.st < 9);
                end
                prev_state = state;
            end
            if (tx_comm_start && prev_cs) begin
                checks++;
                $display("FAIL comm_start_width: got >1 cycle expected 1");
            end else if (tx_comm_start) begin
                if (comm_q.size() == 0) begin
                    checks++;
                    $display("FAIL comm_start: got pulse type %0d, none expected",
                             tx_comm_type);
                end else begin
                    check("comm_type", tx_comm_type, comm_q.pop_front());
                end
            end
            prev_cs = tx_comm_start;
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_state(input int s, input int budget, output int cyc);
        cyc = 0;
        while (state != s && cyc < budget) begin
            step();
            cyc++;
        end
        if (state != s) begin
            checks++;
            $display("FAIL wait_state: got state %0d expected %0d", state, s);
        end
    endtask

    task automatic pulse_status(input int b);
        rx_status[b] = 1'b1;
        step();
        rx_status = '0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [3:0] k);
        rx_data = d;
        rx_k    = k;
        step();
    endtask

    // Starting from a pending WAIT_COMRESET_DONE, walks the handshake to target.
    task automatic run_to(input int target, input int dly, input bit fancy);
        int c;
        rx_elec_idle = 1'b1;
        rx_data = IDLE_W;
        rx_k    = 4'b0000;
        wait_state(3, 10, c);
        push(4);
        pulse_status(0);
        wait_state(4, 5, c);
        if (target == 4) return;
        step(dly);
        push(5);
        push(6);
        comm_q.push_back(1);
        pulse_status(2);
        wait_state(6, 5, c);
        push(7);
        pulse_status(0);
        wait_state(7, 5, c);
        push(8);
        pulse_status(1);
        wait_state(8, 5, c);
        push(9);
        rx_elec_idle = 1'b0;
        wait_state(9, 5, c);
        check("d10_2_data", tx_data, D102_W);
        check("d10_2_k", tx_k, 4'b0000);
        if (target == 9) return;
        push(10);
        send_word(ALIGN_W, 4'b0001);
        rx_data = IDLE_W;
        rx_k    = 4'b0000;
        wait_state(10, 5, c);
        check("align_data", tx_data, ALIGN_W);
        check("align_k", tx_k, 4'b0001);
        if (fancy) begin
            send_word(SYNC_W, 4'b0001);
            send_word(SYNC_W, 4'b0001);
            send_word(ALIGN_W, 4'b0001);
            send_word(SYNC_W, 4'b0001);
            send_word(SYNC_W, 4'b0001);
            push(11);
            send_word(SYNC_W, 4'b0001);
            rx_data = IDLE_W;
            rx_k    = 4'b0000;
            wait_state(11, 5, c);
            check("ready_latency", c, 1);
        end else begin
            push(11);
            repeat (3) send_word(SYNC_W, 4'b0001);
            rx_data = IDLE_W;
            rx_k    = 4'b0000;
            wait_state(11, 6, c);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_state", state, 0);
        check("rst_comm_start", tx_comm_start, 0);
        check("rst_comm_type", tx_comm_type, 0);
        check("rst_elec_idle", tx_elec_idle, 1);
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_k", tx_k, 0);
        check("rst_link_up", link_up, 0);
        check("rst_retry", retry_count, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1);
    end

    initial begin
        int c;
        logic [31:0] d_prev;
        logic [3:0]  k_prev;
        rst = 1'b1;
        phy_reset_done = 1'b1;
        pll_detect_k   = 1'b1;
        dcm_locked     = 1'b1;
        rx_status      = '0;
        rx_elec_idle   = 1'b1;
        rx_data        = IDLE_W;
        rx_k           = 4'b0000;
        user_data      = '0;
        user_k         = '0;
        step(3);
        check_reset_outputs();
        armed = 1'b1;

        // Full bring-up with the SYNC,SYNC,ALIGN,SYNC,SYNC,SYNC pattern.
        push(1);
        push(2);
        push(3);
        comm_q.push_back(0);
        rst = 1'b0;
        run_to(11, 40, 1'b1);

        // User data passthrough, one register deep.
        d_prev = $urandom;
        k_prev = 4'($urandom);
        user_data = d_prev;
        user_k    = k_prev;
        for (int i = 0; i < 4; i++) begin
            step();
            user_data = $urandom;
            user_k    = 4'($urandom);
            check("pass_data", tx_data, d_prev);
            check("pass_k", tx_k, k_prev);
            d_prev = user_data;
            k_prev = user_k;
        end

        // PLL lock lost for one cycle in READY.
        push(1);
        push(2);
        push(3);
        comm_q.push_back(0);
        pll_detect_k = 1'b0;
        step();
        pll_detect_k = 1'b1;
        run_to(11, $urandom_range(1, 45), 1'b0);

        // Device COMINIT while READY: restart without a retry.
        push(2);
        push(3);
        comm_q.push_back(0);
        pulse_status(2);
        run_to(9, $urandom_range(1, 45), 1'b0);

        // Reset pulse during SEND_D10_2.
        push(0);
        rst = 1'b1;
        step();
        check_reset_outputs();
        exp_retry = 0;
        push(1);
        push(2);
        push(3);
        comm_q.push_back(0);
        rst = 1'b0;
        run_to(9, $urandom_range(1, 45), 1'b0);

        // No ALIGN from the device: SEND_D10_2 times out.
        exp_retry++;
        push(2);
        push(3);
        comm_q.push_back(0);
        wait_state(2, AT + 5, c);
        check("align_timeout_cycles", c, AT);

        // Timeout and PLL loss in the same cycle: PHY loss wins, no retry.
        rx_data = IDLE_W;
        rx_k    = 4'b0000;
        wait_state(3, 5, c);
        push(4);
        pulse_status(0);
        wait_state(4, 5, c);
        step(CT - 1);
        push(1);
        push(2);
        push(3);
        comm_q.push_back(0);
        pll_detect_k = 1'b0;
        step();
        pll_detect_k = 1'b1;
        wait_state(3, 10, c);

        // Repeated COMINIT timeouts up to and past saturation.
        for (int i = 0; i < 260; i++) begin
            push(4);
            pulse_status(0);
            wait_state(4, 5, c);
            if (exp_retry < 255) exp_retry++;
            push(2);
            push(3);
            comm_q.push_back(0);
            wait_state(2, CT + 5, c);
            if (i < 3) check("cominit_timeout_cycles", c, CT);
            wait_state(3, 5, c);
        end
        check("retry_saturated", retry_count, 255);
        step(2);
        check("exp_q_empty", exp_q.size(), 0);
        check("comm_q_empty", comm_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
